// File: rtl/go_overlay_pkg.sv
// Shared types and widths for the Game Over overlay sequencer and its helpers.
package go_overlay_pkg;

  localparam int ADDR_W  = 19;
  localparam int RGB_W   = 24;
  localparam int COORD_W = 10;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    BLINK,
    HOLD
  } state_t;

  // A zero frame count would never match the counter, so it is treated as one frame.
  function automatic int at_least_one(input int n);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// VS falling-edge detector producing a one-cycle frame tick, plus a clearable tick counter.
module frame_tick_gen #(
  parameter int CNT_W = go_overlay_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             vs,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] frame_cnt
);

  logic             vs_prev_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign tick      = vs_prev_reg & ~vs;
  assign frame_cnt = cnt_reg;

  // Clear wins over the tick so the owner can restart a count on the very tick it ends one.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      vs_prev_reg <= 1'b1;
      cnt_reg     <= '0;
    end else begin
      vs_prev_reg <= vs;
      if (clr)
        cnt_reg <= '0;
      else if (tick)
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/gameover_overlay_ctrl.sv
// Game Over overlay: delay/blink/hold visibility sequencer, sprite-window addressing,
// and valid/colour-key realignment with the frame RAM's one-cycle registered read.
module gameover_overlay_ctrl
  import go_overlay_pkg::*;
#(
  parameter int          SPR_W         = 128,
  parameter int          SPR_H         = 64,
  parameter int          X0            = 256,
  parameter int          Y0            = 208,
  parameter int          DELAY_FRAMES  = 30,
  parameter int          BLINK_FRAMES  = 15,
  parameter int          BLINK_TOGGLES = 6,
  parameter bit          KEY_EN        = 1'b1,
  parameter logic [23:0] KEY_RGB       = 24'h000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        VS,
  input  logic        game_over,
  input  logic        restart,
  output logic [18:0] read_address,
  input  logic [23:0] ram_data,
  output logic        pixel_valid,
  output logic [23:0] pixel_rgb,
  output logic        overlay_active
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(at_least_one(DELAY_FRAMES) - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(at_least_one(BLINK_FRAMES) - 1);
  localparam logic [7:0]       TOG_LAST   = 8'(BLINK_TOGGLES - 1);
  localparam bit               NO_BLINK   = (BLINK_TOGGLES < 1);
  localparam logic [11:0]      X_LO       = 12'(X0);
  localparam logic [11:0]      X_HI       = 12'(X0 + SPR_W - 1);
  localparam logic [11:0]      Y_LO       = 12'(Y0);
  localparam logic [11:0]      Y_HI       = 12'(Y0 + SPR_H - 1);

  state_t             state_reg, state_next;
  logic               visible_reg, visible_next;
  logic [7:0]         tog_reg, tog_next;
  logic               tick, cnt_clr;
  logic [CNT_W-1:0]   frame_cnt;

  frame_tick_gen #(.CNT_W(CNT_W)) u_frame_tick (
    .clk      (Clk),
    .srst_n   (Reset),
    .vs       (VS),
    .clr      (cnt_clr),
    .tick     (tick),
    .frame_cnt(frame_cnt)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg   <= IDLE;
      visible_reg <= 1'b0;
      tog_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      visible_reg <= visible_next;
      tog_reg     <= tog_next;
    end
  end

  // Visibility only moves on frame ticks, so the overlay never tears mid-frame.
  always_comb begin
    state_next   = state_reg;
    visible_next = visible_reg;
    tog_next     = tog_reg;
    cnt_clr      = 1'b0;
    if (restart) begin
      state_next   = IDLE;
      visible_next = 1'b0;
      tog_next     = '0;
      cnt_clr      = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          visible_next = 1'b0;
          tog_next     = '0;
          cnt_clr      = 1'b1;
          if (game_over)
            state_next = DELAY;
        end
        DELAY: begin
          if (tick && frame_cnt == DELAY_LAST) begin
            state_next   = NO_BLINK ? HOLD : BLINK;
            visible_next = 1'b1;
            tog_next     = '0;
            cnt_clr      = 1'b1;
          end
        end
        BLINK: begin
          if (tick && frame_cnt == BLINK_LAST) begin
            visible_next = ~visible_reg;
            tog_next     = tog_reg + 8'd1;
            cnt_clr      = 1'b1;
            if (tog_reg == TOG_LAST) begin
              state_next   = HOLD;
              visible_next = 1'b1;
            end
          end
        end
        HOLD: visible_next = 1'b1;
        default: state_next = IDLE;
      endcase
    end
  end

  logic               in_win;
  logic [COORD_W-1:0] dx, dy;
  logic [ADDR_W-1:0]  addr_calc;
  logic [ADDR_W-1:0]  addr_reg;
  logic               v1_reg, v2_reg;

  assign in_win = visible_reg
                && ({2'b00, DrawX} >= X_LO) && ({2'b00, DrawX} <= X_HI)
                && ({2'b00, DrawY} >= Y_LO) && ({2'b00, DrawY} <= Y_HI);

  // Offsets only reach the address register when in window, so wrap-around is never seen.
  assign dx        = DrawX - COORD_W'(X0);
  assign dy        = DrawY - COORD_W'(Y0);
  assign addr_calc = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      addr_reg <= '0;
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
    end else begin
      addr_reg <= in_win ? addr_calc : '0;
      v1_reg   <= in_win;
      v2_reg   <= v1_reg;
    end
  end

  assign read_address   = addr_reg;
  assign pixel_valid    = v2_reg && !(KEY_EN && (ram_data == KEY_RGB));
  assign pixel_rgb      = pixel_valid ? ram_data : '0;
  assign overlay_active = (state_reg != IDLE);

endmodule

// File: tb/tb_gameover_overlay_ctrl.sv
// Scoreboard bench for gameover_overlay_ctrl: stimulus queues expected responses, a negedge monitor compares them.
module tb_gameover_overlay_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        VS = 1'b1;
  logic        game_over = 1'b0;
  logic        restart = 1'b0;
  logic [18:0] read_address;
  logic [23:0] ram_data;
  logic        pixel_valid;
  logic [23:0] pixel_rgb;
  logic        overlay_active;

  logic        use_pattern = 1'b1;
  logic [23:0] ram_const = '0;
  int unsigned edges = 0;
  int          checks = 0;
  int          failures = 0;

  typedef enum int {K_ADDR, K_PIX, K_ACT} kind_t;
  typedef struct {
    int unsigned due;
    kind_t       kind;
    logic [23:0] exp_val;
    logic        exp_bit;
    string       name;
  } exp_t;
  exp_t sb[$];

  gameover_overlay_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .VS            (VS),
    .game_over     (game_over),
    .restart       (restart),
    .read_address  (read_address),
    .ram_data      (ram_data),
    .pixel_valid   (pixel_valid),
    .pixel_rgb     (pixel_rgb),
    .overlay_active(overlay_active)
  );

  initial forever #5 Clk = ~Clk;

  always @(posedge Clk) edges <= edges + 1;

  // Frame RAM model with a registered read; the pattern makes each address's data unique and non-key.
  always @(posedge Clk) ram_data <= use_pattern ? {5'h1F, read_address} : ram_const;

  task automatic check_entry(input exp_t e);
    checks++;
    case (e.kind)
      K_ADDR: begin
        if (read_address !== e.exp_val[18:0]) begin
          failures++;
          $display("FAIL %s: read_address=%0d required %0d", e.name, read_address, e.exp_val[18:0]);
        end else
          $display("ok %s: read_address=%0d", e.name, read_address);
      end
      K_PIX: begin
        if (pixel_valid !== e.exp_bit || pixel_rgb !== e.exp_val) begin
          failures++;
          $display("FAIL %s: pixel_valid=%b pixel_rgb=%h required %b/%h", e.name, pixel_valid, pixel_rgb, e.exp_bit, e.exp_val);
        end else
          $display("ok %s: pixel_valid=%b pixel_rgb=%h", e.name, pixel_valid, pixel_rgb);
      end
      default: begin
        if (overlay_active !== e.exp_bit) begin
          failures++;
          $display("FAIL %s: overlay_active=%b required %b", e.name, overlay_active, e.exp_bit);
        end else
          $display("ok %s: overlay_active=%b", e.name, overlay_active);
      end
    endcase
  endtask

  always @(negedge Clk) begin : monitor
    int idx;
    idx = 0;
    while (idx < sb.size()) begin
      if (sb[idx].due == edges) begin
        check_entry(sb[idx]);
        sb.delete(idx);
      end else
        idx++;
    end
  end

  task automatic push(input int unsigned lat, input kind_t k, input logic [23:0] v, input logic b, input string n);
    exp_t e;
    e.due = edges + lat;
    e.kind = k;
    e.exp_val = v;
    e.exp_bit = b;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic chk_pix(input int unsigned lat, input logic vis, input logic [23:0] rgb, input string n);
    push(lat, K_PIX, vis ? rgb : 24'h0, vis, n);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic frame();
    VS = 1'b0;
    steps(2);
    VS = 1'b1;
    steps(4);
  endtask

  // Expected visibility after the n-th frame tick since game_over.
  function automatic logic exp_vis(input int n);
    int k;
    if (n < 30) return 1'b0;
    k = (n - 30) / 15;
    if (k >= 6) return 1'b1;
    return (k % 2) == 0;
  endfunction

  initial begin
    for (int c = 0; c < 3; c++) begin
      Reset = 1'b0;
      DrawX = 10'($urandom_range(0, 1023));
      DrawY = 10'($urandom_range(0, 1023));
      VS = 1'($urandom_range(0, 1));
      game_over = 1'($urandom_range(0, 1));
      restart = 1'($urandom_range(0, 1));
      push(1, K_ADDR, 24'h0, 1'b0, "rst_addr");
      chk_pix(1, 1'b0, 24'h0, "rst_pix");
      push(1, K_ACT, 24'h0, 1'b0, "rst_active");
      step();
    end

    Reset = 1'b1;
    VS = 1'b1;
    game_over = 1'b0;
    restart = 1'b0;
    DrawX = 10'd256;
    DrawY = 10'd208;
    push(1, K_ACT, 24'h0, 1'b0, "idle_after_reset");
    steps(2);
    chk_pix(1, 1'b0, 24'h0, "idle_pix");
    step();

    game_over = 1'b1;
    restart = 1'b1;
    push(1, K_ACT, 24'h0, 1'b0, "go_and_restart_idle");
    step();
    game_over = 1'b0;
    restart = 1'b0;
    push(1, K_ACT, 24'h0, 1'b0, "still_idle");
    steps(2);

    game_over = 1'b1;
    push(1, K_ACT, 24'h0, 1'b1, "active_on_game_over");
    step();
    game_over = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      frame();
      chk_pix(1, exp_vis(n), 24'hF80000, $sformatf("delay_tick%0d", n));
      if (n == 10) begin
        step();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
      end
    end
    push(1, K_ADDR, 24'h0, 1'b0, "first_vis_addr");
    steps(2);

    DrawX = 10'd0;
    steps(3);
    DrawX = 10'd257;
    push(1, K_ADDR, 24'd1, 1'b0, "lat_addr_1edge");
    chk_pix(1, 1'b0, 24'h0, "lat_pix_1edge");
    chk_pix(2, 1'b1, 24'hF80001, "lat_pix_2edge");
    steps(3);
    DrawX = 10'd256;
    steps(3);

    for (int n = 31; n <= 170; n++) begin
      frame();
      chk_pix(1, exp_vis(n), 24'hF80000, $sformatf("blink_tick%0d", n));
      if (n == 120 || n == 170) push(1, K_ACT, 24'h0, 1'b1, $sformatf("active_tick%0d", n));
    end

    DrawX = 10'd383; DrawY = 10'd271;
    push(1, K_ADDR, 24'd8191, 1'b0, "addr_bottom_right");
    chk_pix(2, 1'b1, 24'hF81FFF, "pix_bottom_right");
    steps(3);
    DrawX = 10'd384; DrawY = 10'd271;
    push(1, K_ADDR, 24'h0, 1'b0, "addr_x_past_right");
    chk_pix(2, 1'b0, 24'h0, "pix_x_past_right");
    steps(3);
    DrawX = 10'd256; DrawY = 10'd207;
    push(1, K_ADDR, 24'h0, 1'b0, "addr_y_above_top");
    chk_pix(2, 1'b0, 24'h0, "pix_y_above_top");
    steps(3);
    DrawX = 10'd255; DrawY = 10'd208;
    chk_pix(2, 1'b0, 24'h0, "pix_x_left_of_win");
    steps(3);
    DrawX = 10'd256; DrawY = 10'd271;
    push(1, K_ADDR, 24'd8064, 1'b0, "addr_bottom_left");
    chk_pix(2, 1'b1, 24'hF81F80, "pix_bottom_left");
    steps(3);
    DrawX = 10'd300; DrawY = 10'd230;
    use_pattern = 1'b0;
    ram_const = 24'h000000;
    push(1, K_ADDR, 24'd2860, 1'b0, "addr_mid");
    chk_pix(2, 1'b0, 24'h0, "pix_keyed_black");
    steps(3);
    ram_const = 24'h123456;
    chk_pix(2, 1'b1, 24'h123456, "pix_const_colour");
    steps(3);
    use_pattern = 1'b1;

    DrawX = 10'd256; DrawY = 10'd208;
    steps(3);
    restart = 1'b1;
    push(1, K_ACT, 24'h0, 1'b0, "restart_from_hold");
    chk_pix(3, 1'b0, 24'h0, "pix_off_after_hold_restart");
    step();
    restart = 1'b0;
    steps(3);

    game_over = 1'b1;
    step();
    game_over = 1'b0;
    for (int n = 1; n <= 32; n++) frame();
    chk_pix(1, 1'b1, 24'hF80000, "second_run_blink_visible");
    push(1, K_ACT, 24'h0, 1'b1, "second_run_active");
    step();
    restart = 1'b1;
    push(1, K_ACT, 24'h0, 1'b0, "restart_in_blink");
    chk_pix(3, 1'b0, 24'h0, "blink_pix_off_in_2");
    step();
    restart = 1'b0;
    steps(3);
    frame();
    chk_pix(1, 1'b0, 24'h0, "idle_after_tick");
    push(1, K_ACT, 24'h0, 1'b0, "idle_after_restart");
    steps(2);

    for (int w = 0; w < 20 && sb.size() > 0; w++) step();
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
